fifo_sync_thresh: RTL

//  Parametrised single-clock FIFO, successor to the basic fifo block. Supports any DEPTH >= 2, including non-power-of-2.

---
 rtl/fifo_sync_thresh_if.sv | 31 +++
 rtl/fifo_sync_thresh.sv | 92 +++++++++
 2 files changed

// File: rtl/fifo_sync_thresh_if.sv
// rtl/fifo_sync_thresh_if.sv - producer/consumer bundle for fifo_sync_thresh
interface fifo_sync_thresh_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int CW        = $clog2(DEPTH + 1)
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, din, rd_en,
    input  dout, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en,
    output dout, rd_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_thresh.sv
// rtl/fifo_sync_thresh.sv - single-clock FIFO with count, thresholds and over/underflow pulses
// Define FIFO_FWFT_EN for first-word-fall-through reads; default is registered read, latency 1.
module fifo_sync_thresh #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int AF_THRESH  = DEPTH - 1,
  parameter int AE_THRESH  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  fifo_sync_thresh_if.slave  bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  overflow_q, underflow_q;
  logic                  full, empty;
  logic                  wr_acc, rd_acc;

  assign full   = (count_q == CW'(DEPTH));
  assign empty  = (count_q == '0);
  // A read in the same cycle frees a slot, so a full FIFO still takes the write.
  assign wr_acc = bus.wr_en & (~full | bus.rd_en);
  assign rd_acc = bus.rd_en & ~empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (rd_acc) rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= bus.wr_en & ~wr_acc;
      underflow_q <= bus.rd_en & ~rd_acc;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wr_ptr_q] <= bus.din;
  end

`ifdef FIFO_FWFT_EN
  assign bus.dout     = empty ? '0 : mem[rd_ptr_q];
  assign bus.rd_valid = ~empty;
`else
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  rd_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q     <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) dout_q <= mem[rd_ptr_q];
    end
  end

  assign bus.dout     = dout_q;
  assign bus.rd_valid = rd_valid_q;
`endif

  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = (count_q >= CW'(AF_THRESH));
  assign bus.almost_empty = (count_q <= CW'(AE_THRESH));
  assign bus.count        = count_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;
endmodule
